// File: rtl/enable_sequencer_if.sv
// Control/status bundle between board-level control and the enable sequencer.
interface enable_sequencer_if #(
    parameter int NUM_CH = 4
) ();
    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] odata;
    logic              busy;
    logic              done;

    modport master (output start, output abort, input odata, input busy, input done);
    modport slave  (input start, input abort, output odata, output busy, output done);
endinterface

// File: rtl/enable_sequencer.sv
// Staggered power-up / power-down sequencer for NUM_CH enable lines.
//
//   state | meaning
//   IDLE  | all enables off, waiting for start (abort blocks start)
//   UP    | raising one enable every STEP_DLY cycles, bit 0 first
//   ON    | all enables on, waiting for abort
//   DOWN  | dropping the highest enable every STEP_DLY cycles until none left
module enable_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int DLY_W      = 16,
    parameter int STEP_DLY   = 1000,
    parameter int REV_ON_ABT = 1
) (
    input  logic                    sclk,
    input  logic                    rst,
    enable_sequencer_if.slave       bus
);
    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam logic [DLY_W-1:0] LAST_CNT = DLY_W'(STEP_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, UP, ON, DOWN} state_t;

    state_t            state, state_nxt;
    logic [DLY_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [NUM_CH-1:0] odata, odata_nxt;
    logic              busy, done;

    // Next-state, step timer and enable-count decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = UP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            UP: begin
                if (bus.abort) begin
                    // A pending set is dropped; shutdown starts from the current pattern.
                    cnt_nxt = '0;
                    if (REV_ON_ABT == 0 || idx == '0) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = DOWN;
                    end
                end else if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state_nxt = ON;
                    end
                end else begin
                    cnt_nxt = cnt + DLY_W'(1);
                end
            end
            ON: begin
                if (bus.abort) begin
                    cnt_nxt = '0;
                    if (REV_ON_ABT == 0) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = DOWN;
                    end
                end
            end
            DOWN: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    idx_nxt = idx - IDX_W'(1);
                    if (idx == IDX_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + DLY_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Enables are always a contiguous run of ones from bit 0, idx long.
    always_comb begin
        odata_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            odata_nxt[i] = (IDX_W'(i) < idx_nxt);
        end
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            odata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            odata <= odata_nxt;
            busy  <= (state_nxt == UP) || (state_nxt == DOWN);
            done  <= (state_nxt == ON);
        end
    end

    assign bus.odata = odata;
    assign bus.busy  = busy;
    assign bus.done  = done;
endmodule

// File: tb/tb_enable_sequencer.sv
// Directed bench: expected output snapshots are queued per edge and checked by a monitor.
module tb_enable_sequencer;
    logic sclk = 1'b0;
    logic rst  = 1'b1;

    enable_sequencer_if #(.NUM_CH(4)) bus_a ();
    enable_sequencer_if #(.NUM_CH(4)) bus_b ();

    enable_sequencer #(.NUM_CH(4), .DLY_W(16), .STEP_DLY(3), .REV_ON_ABT(1)) dut_a (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus_a.slave)
    );

    enable_sequencer #(.NUM_CH(4), .DLY_W(16), .STEP_DLY(3), .REV_ON_ABT(0)) dut_b (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus_b.slave)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int         e;
        logic [5:0] v;   // {odata, busy, done}
        string      tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic exp_a(input int e, input logic [3:0] od, input logic b, input logic d, input string tag);
        exp_t x;
        x.e = e; x.v = {od, b, d}; x.tag = tag;
        q_a.push_back(x);
    endtask

    task automatic exp_b(input int e, input logic [3:0] od, input logic b, input logic d, input string tag);
        exp_t x;
        x.e = e; x.v = {od, b, d}; x.tag = tag;
        q_b.push_back(x);
    endtask

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s at edge %0d: odata/busy/done got %b/%b/%b expected %b/%b/%b",
                   tag, edge_n, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
        end
    endtask

    // Monitor: count edges and compare any snapshot due at this edge, 1 time unit after it.
    initial begin
        forever begin
            @(posedge sclk);
            edge_n++;
            #1;
            while (q_a.size() > 0 && q_a[0].e == edge_n) begin
                check(q_a[0].tag, {bus_a.odata, bus_a.busy, bus_a.done}, q_a[0].v);
                void'(q_a.pop_front());
            end
            while (q_b.size() > 0 && q_b[0].e == edge_n) begin
                check(q_b[0].tag, {bus_b.odata, bus_b.busy, bus_b.done}, q_b[0].v);
                void'(q_b.pop_front());
            end
        end
    end

    // Return just after edge n; inputs set now are sampled at edge n+1.
    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge sclk);
            #2;
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;

        // Reset
        exp_a(2,  4'b0000, 0, 0, "reset");
        // Power-up, start sampled at edge 5
        exp_a(5,  4'b0000, 1, 0, "up_enter");
        exp_a(7,  4'b0000, 1, 0, "up_wait0");
        exp_a(8,  4'b0001, 1, 0, "up_bit0");
        exp_a(11, 4'b0011, 1, 0, "up_bit1");
        exp_a(14, 4'b0111, 1, 0, "up_bit2");
        exp_a(16, 4'b0111, 1, 0, "up_wait3");
        exp_a(17, 4'b1111, 0, 1, "up_on");
        exp_a(20, 4'b1111, 0, 1, "on_hold");
        // Reverse shutdown from ON, abort sampled at edge 25; start pulse at 29 ignored
        exp_a(24, 4'b1111, 0, 1, "on_pre_abort");
        exp_a(25, 4'b1111, 1, 0, "down_enter");
        exp_a(28, 4'b0111, 1, 0, "down_bit3");
        exp_a(30, 4'b0111, 1, 0, "down_start_ignored");
        exp_a(31, 4'b0011, 1, 0, "down_bit2");
        exp_a(34, 4'b0001, 1, 0, "down_bit1");
        exp_a(37, 4'b0000, 0, 0, "down_idle");
        // Abort during UP at edge 52 with 0011 showing
        exp_a(51, 4'b0011, 1, 0, "upabt_pre");
        exp_a(52, 4'b0011, 1, 0, "upabt_enter");
        exp_a(54, 4'b0011, 1, 0, "upabt_no_0111");
        exp_a(55, 4'b0001, 1, 0, "upabt_bit1");
        exp_a(57, 4'b0001, 1, 0, "upabt_hold");
        exp_a(58, 4'b0000, 0, 0, "upabt_idle");
        exp_a(59, 4'b0000, 0, 0, "upabt_stay");
        // start and abort together in IDLE
        exp_a(65, 4'b0000, 0, 0, "idle_blocked");
        exp_a(68, 4'b0000, 0, 0, "idle_blocked_hold");
        // Mid-UP reset at edge 82, restart sampled at 85
        exp_a(81, 4'b0011, 1, 0, "rst_pre");
        exp_a(82, 4'b0000, 0, 0, "rst_mid_up");
        exp_a(85, 4'b0000, 1, 0, "reup_enter");
        exp_a(88, 4'b0001, 1, 0, "reup_bit0");
        exp_a(97, 4'b1111, 0, 1, "reup_on");

        // Instance without reverse shutdown: abort in ON drops everything at once
        exp_b(2,  4'b0000, 0, 0, "b_reset");
        exp_b(17, 4'b1111, 0, 1, "b_on");
        exp_b(19, 4'b1111, 0, 1, "b_pre_abort");
        exp_b(20, 4'b0000, 0, 0, "b_abort_all");
        exp_b(21, 4'b0000, 0, 0, "b_idle");

        step_to(2);  rst = 1'b0;
        step_to(4);  bus_a.start = 1'b1; bus_b.start = 1'b1;
        step_to(5);  bus_a.start = 1'b0; bus_b.start = 1'b0;
        step_to(19); bus_b.abort = 1'b1;
        step_to(20); bus_b.abort = 1'b0;
        step_to(24); bus_a.abort = 1'b1;
        step_to(25); bus_a.abort = 1'b0;
        step_to(28); bus_a.start = 1'b1;
        step_to(29); bus_a.start = 1'b0;
        step_to(44); bus_a.start = 1'b1;
        step_to(45); bus_a.start = 1'b0;
        step_to(51); bus_a.abort = 1'b1;
        step_to(52); bus_a.abort = 1'b0;
        step_to(64); bus_a.start = 1'b1; bus_a.abort = 1'b1;
        step_to(68); bus_a.start = 1'b0; bus_a.abort = 1'b0;
        step_to(74); bus_a.start = 1'b1;
        step_to(75); bus_a.start = 1'b0;
        step_to(81); rst = 1'b1;
        step_to(82); rst = 1'b0;
        step_to(84); bus_a.start = 1'b1;
        step_to(85); bus_a.start = 1'b0;
        step_to(100);

        // Any snapshot never reached counts as a failed check.
        n_checks++;
        assert ((q_a.size() + q_b.size()) == 0) else begin
            n_fails++;
            $error("FAIL pending_snapshots: got %0d left, expected 0", q_a.size() + q_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
